// File: rtl/lane_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lane_packer_pkg
// Description : Shared constants and types for the lane packer
//               (lane count, word width, lane index type, round-robin helper).
// Revision    : 1.0 - initial release
// ============================================================================
package lane_packer_pkg;

  localparam int LANES = 4;
  localparam int NIB_W = 4;

  typedef logic [1:0]       lane_idx_t;
  typedef logic [NIB_W-1:0] nib_t;

  // Lane index reached by stepping 'off' lanes past 'base', wrapping at LANES.
  function automatic lane_idx_t rr_idx(input lane_idx_t base, input int unsigned off);
    return base + lane_idx_t'(off);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lane_packer_deser.sv
`default_nettype none
// ============================================================================
// Module      : lane_deser
// Description : Per-lane LSB-first deserializer. Gathers NIB_W bits into a
//               shift register, hands completed words to a single holding
//               register, and flags a sticky overflow when a word completes
//               while the holding register is still occupied.
// Revision    : 1.0 - initial release
// ============================================================================
module lane_deser
  import lane_packer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en_i,
  input  logic             bit_i,
  input  logic             drain_i,
  output logic             full_o,
  output logic [NIB_W-1:0] hold_o,
  output logic             ovf_o
);

  localparam logic [1:0] C_LAST_CNT = 2'd3;

  logic [NIB_W-1:0] sh_q,   sh_d;
  logic [NIB_W-1:0] hold_q, hold_d;
  logic [1:0]       cnt_q,  cnt_d;
  logic             full_q, full_d;
  logic             ovf_q,  ovf_d;
  logic [NIB_W-1:0] w_shifted;

  assign w_shifted = {bit_i, sh_q[NIB_W-1:1]};

  // Next-state: shift, complete a word, or drop the completing bit on overflow.
  always_comb begin
    sh_d   = sh_q;
    cnt_d  = cnt_q;
    hold_d = hold_q;
    full_d = full_q & ~drain_i;
    ovf_d  = ovf_q;
    if (shift_en_i) begin
      if (cnt_q == C_LAST_CNT) begin
        // A drain in this same cycle frees the holding register in time.
        if (full_q && !drain_i) begin
          ovf_d = 1'b1;
        end else begin
          sh_d   = w_shifted;
          cnt_d  = 2'd0;
          hold_d = w_shifted;
          full_d = 1'b1;
        end
      end else begin
        sh_d  = w_shifted;
        cnt_d = cnt_q + 2'd1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q   <= '0;
      hold_q <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      hold_q <= hold_d;
      cnt_q  <= cnt_d;
      full_q <= full_d;
      ovf_q  <= ovf_d;
    end
  end

  assign full_o = full_q;
  assign hold_o = hold_q;
  assign ovf_o  = ovf_q;

endmodule
`default_nettype wire

// File: rtl/lane_packer.sv
`default_nettype none
// ============================================================================
// Module      : lane_packer
// Description : Routes single bits into LANES deserializers, then emits the
//               packed words through one valid/ready output register chosen
//               by a round-robin arbiter over lanes with a full holding word.
// Revision    : 1.0 - initial release
// ============================================================================
module lane_packer
  import lane_packer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [1:0]       in_sel,
  input  logic             in_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NIB_W-1:0] out_data,
  output logic [1:0]       out_lane,
  output logic [LANES-1:0] ovf
);

  logic [LANES-1:0] w_full;
  logic [LANES-1:0] w_shift_en;
  logic [LANES-1:0] w_drain;
  logic [LANES-1:0] w_ovf;
  nib_t             w_hold [LANES];

  logic             w_any;
  lane_idx_t        w_sel;
  logic             w_load;

  logic             out_valid_q, out_valid_d;
  nib_t             out_data_q,  out_data_d;
  lane_idx_t        out_lane_q,  out_lane_d;
  lane_idx_t        rr_q,        rr_d;

  generate
    for (genvar g = 0; g < LANES; g++) begin : g_lane
      assign w_shift_en[g] = in_valid && (in_sel == lane_idx_t'(g));

      lane_deser u_deser (
        .clk        (clk),
        .rst        (rst),
        .shift_en_i (w_shift_en[g]),
        .bit_i      (in_bit),
        .drain_i    (w_drain[g]),
        .full_o     (w_full[g]),
        .hold_o     (w_hold[g]),
        .ovf_o      (w_ovf[g])
      );
    end
  endgenerate

  // Round-robin pick: first full lane at or after the rr pointer.
  always_comb begin
    w_any = 1'b0;
    w_sel = rr_q;
    for (int i = 0; i < LANES; i++) begin
      if (!w_any && w_full[rr_idx(rr_q, i)]) begin
        w_any = 1'b1;
        w_sel = rr_idx(rr_q, i);
      end
    end
  end

  // Output register is free when empty or being consumed this cycle.
  assign w_load = w_any && (!out_valid_q || out_ready);

  // Output register next-state, drain strobe and pointer advance.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_lane_d  = out_lane_q;
    rr_d        = rr_q;
    w_drain     = '0;
    if (w_load) begin
      out_valid_d    = 1'b1;
      out_data_d     = w_hold[w_sel];
      out_lane_d     = w_sel;
      rr_d           = w_sel + lane_idx_t'(1);
      w_drain[w_sel] = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register and arbiter pointer with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_lane_q  <= '0;
      rr_q        <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_lane_q  <= out_lane_d;
      rr_q        <= rr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_lane  = out_lane_q;
  assign ovf       = w_ovf;

endmodule
`default_nettype wire
